hqc_rmdecod_findpeaks: RTL and testbench

HQC_RMDECOD_FINDPEAKS -- requirements
Module: hqc_rmdecod_findpeaks

---
 rtl/hqc_rmdecod_findpeaks_pkg.sv | 14 +
 rtl/hqc_findpeaks_cmp.sv | 31 +++
 rtl/hqc_rmdecod_findpeaks.sv | 202 ++++++++++++++++++++
 tb/tb_hqc_rmdecod_findpeaks.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hqc_rmdecod_findpeaks_pkg.sv
// Shared constants for the HQC Reed-Muller peak finder: block geometry and
// the coefficient width implied by the security level.
package hqc_rmdecod_findpeaks_pkg;

  localparam int PAIRS_PER_BLOCK = 64;
  localparam int IDX_W           = 7;
  localparam int PAIR_CNT_W      = $clog2(PAIRS_PER_BLOCK);

  // Hadamard coefficients grow by one bit for the two larger parameter sets.
  function automatic int din_w_of(input int security);
    return (security == 128) ? 10 : 11;
  endfunction

endpackage

// File: rtl/hqc_findpeaks_cmp.sv
// Magnitude compare-and-select: returns operand b only when |b| > |a|, so
// operand a wins every tie.
module hqc_findpeaks_cmp
  import hqc_rmdecod_findpeaks_pkg::*;
#(
  parameter int DIN_W = 10
) (
  input  logic signed [DIN_W-1:0] a_val_i,
  input  logic        [IDX_W-1:0] a_idx_i,
  input  logic signed [DIN_W-1:0] b_val_i,
  input  logic        [IDX_W-1:0] b_idx_i,
  output logic signed [DIN_W-1:0] win_val_o,
  output logic        [IDX_W-1:0] win_idx_o,
  output logic        [DIN_W-1:0] win_abs_o
);

  logic [DIN_W-1:0] a_abs;
  logic [DIN_W-1:0] b_abs;
  logic             b_wins;

  always_comb begin
    // Unsigned result keeps the most negative code as +2^(DIN_W-1).
    a_abs     = a_val_i[DIN_W-1] ? DIN_W'(-a_val_i) : DIN_W'(a_val_i);
    b_abs     = b_val_i[DIN_W-1] ? DIN_W'(-b_val_i) : DIN_W'(b_val_i);
    b_wins    = (b_abs > a_abs);
    win_val_o = b_wins ? b_val_i : a_val_i;
    win_idx_o = b_wins ? b_idx_i : a_idx_i;
    win_abs_o = b_wins ? b_abs   : a_abs;
  end

endmodule

// File: rtl/hqc_rmdecod_findpeaks.sv
// Finds the largest-magnitude coefficient of a 128-entry Hadamard block fed as
// 64 pairs; optional peak magnitude output under HQC_FINDPEAKS_PEAKABS_EN.
module hqc_rmdecod_findpeaks
  import hqc_rmdecod_findpeaks_pkg::*;
#(
  parameter int PARAM_SECURITY = 128,
  parameter int DIN_W          = din_w_of(PARAM_SECURITY)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic signed [DIN_W-1:0] din0_i,
  input  logic signed [DIN_W-1:0] din1_i,
  input  logic                    din_valid_i,
  output logic        [7:0]       dout_o,
  output logic                    dout_valid_o,
  output logic                    busy_o
`ifdef HQC_FINDPEAKS_PEAKABS_EN
  ,
  output logic        [DIN_W-1:0] peak_abs_o
`endif
);

  localparam logic [PAIR_CNT_W-1:0] LAST_PAIR = PAIR_CNT_W'(PAIRS_PER_BLOCK - 1);

  // Pair counter and busy flag
  logic [PAIR_CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic                  busy_q, busy_d;
  logic                  pair_first, pair_last;
  logic [IDX_W-1:0]      idx0, idx1;

  // Stage 1: winner of the incoming pair
  logic signed [DIN_W-1:0] pair_val;
  logic [IDX_W-1:0]        pair_idx;
  logic [DIN_W-1:0]        pair_abs;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_first_q, s1_first_d;
  logic                    s1_last_q,  s1_last_d;
  logic signed [DIN_W-1:0] s1_val_q,   s1_val_d;
  logic [IDX_W-1:0]        s1_idx_q,   s1_idx_d;
  logic [DIN_W-1:0]        s1_abs_q,   s1_abs_d;

  // Stage 2: running best of the block
  logic signed [DIN_W-1:0] cand_val;
  logic [IDX_W-1:0]        cand_idx;
  logic [DIN_W-1:0]        cand_abs;
  logic                    s2_valid_q, s2_valid_d;
  logic signed [DIN_W-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0]        best_idx_q, best_idx_d;
  logic [DIN_W-1:0]        best_abs_q, best_abs_d;

  // Output register
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    cnt_eff    = start_i ? '0 : cnt_q;
    pair_first = (cnt_eff == '0);
    pair_last  = (cnt_eff == LAST_PAIR);
    idx0       = {cnt_eff, 1'b0};
    idx1       = {cnt_eff, 1'b1};
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    if (start_i) begin
      cnt_d  = '0;
      busy_d = 1'b1;
    end
    // A pair coinciding with start_i is pair 0 of the new block; the counter
    // wraps after pair 63 so an unannounced next block starts at 0.
    if (din_valid_i) begin
      cnt_d  = cnt_eff + 1'b1;
      busy_d = !pair_last;
    end
  end

  hqc_findpeaks_cmp #(.DIN_W(DIN_W)) u_pair_cmp (
    .a_val_i   (din0_i),
    .a_idx_i   (idx0),
    .b_val_i   (din1_i),
    .b_idx_i   (idx1),
    .win_val_o (pair_val),
    .win_idx_o (pair_idx),
    .win_abs_o (pair_abs)
  );

  always_comb begin
    s1_valid_d = din_valid_i;
    s1_first_d = din_valid_i & pair_first;
    s1_last_d  = din_valid_i & pair_last;
    s1_val_d   = s1_val_q;
    s1_idx_d   = s1_idx_q;
    s1_abs_d   = s1_abs_q;
    if (din_valid_i) begin
      s1_val_d = pair_val;
      s1_idx_d = pair_idx;
      s1_abs_d = pair_abs;
    end
  end

  hqc_findpeaks_cmp #(.DIN_W(DIN_W)) u_best_cmp (
    .a_val_i   (best_val_q),
    .a_idx_i   (best_idx_q),
    .b_val_i   (s1_val_q),
    .b_idx_i   (s1_idx_q),
    .win_val_o (cand_val),
    .win_idx_o (cand_idx),
    .win_abs_o (cand_abs)
  );

  // The last-pair flag travels with the data, so a new start_i never
  // disturbs a block that is already draining through the pipeline.
  always_comb begin
    s2_valid_d = s1_valid_q & s1_last_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    best_abs_d = best_abs_q;
    if (s1_valid_q) begin
      if (s1_first_q) begin
        best_val_d = s1_val_q;
        best_idx_d = s1_idx_q;
        best_abs_d = s1_abs_q;
      end else begin
        best_val_d = cand_val;
        best_idx_d = cand_idx;
        best_abs_d = cand_abs;
      end
    end
  end

  always_comb begin
    dout_valid_d = s2_valid_q;
    dout_d       = dout_q;
    if (s2_valid_q) begin
      dout_d = {(best_abs_q != '0) && !best_val_q[DIN_W-1], best_idx_q};
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: data registers are cleared along with control so the reset state is fully defined.
    if (rst_i) begin
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_val_q     <= '0;
      s1_idx_q     <= '0;
      s1_abs_q     <= '0;
      s2_valid_q   <= 1'b0;
      best_val_q   <= '0;
      best_idx_q   <= '0;
      best_abs_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      s1_valid_q   <= s1_valid_d;
      s1_first_q   <= s1_first_d;
      s1_last_q    <= s1_last_d;
      s1_val_q     <= s1_val_d;
      s1_idx_q     <= s1_idx_d;
      s1_abs_q     <= s1_abs_d;
      s2_valid_q   <= s2_valid_d;
      best_val_q   <= best_val_d;
      best_idx_q   <= best_idx_d;
      best_abs_q   <= best_abs_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign busy_o       = busy_q;

`ifdef HQC_FINDPEAKS_PEAKABS_EN
  logic [DIN_W-1:0] peak_abs_q, peak_abs_d;

  always_comb begin
    peak_abs_d = peak_abs_q;
    if (s2_valid_q) begin
      peak_abs_d = best_abs_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      peak_abs_q <= '0;
    end else begin
      peak_abs_q <= peak_abs_d;
    end
  end

  assign peak_abs_o = peak_abs_q;
`else
  // The peak magnitude is only needed internally for the sign decision.
`endif

endmodule

// File: tb/tb_hqc_rmdecod_findpeaks.sv
// Scoreboard bench for hqc_rmdecod_findpeaks: directed corner blocks plus
// randomized blocks, checked against an argmax-of-|x| reference model.
module tb_hqc_rmdecod_findpeaks;
  import hqc_rmdecod_findpeaks_pkg::*;

  localparam int DIN_W = din_w_of(128);

  logic                    clk = 1'b0;
  logic                    rst_i, start_i, din_valid_i;
  logic signed [DIN_W-1:0] din0_i, din1_i;
  logic [7:0]              dout_o;
  logic                    dout_valid_o, busy_o;
`ifdef HQC_FINDPEAKS_PEAKABS_EN
  logic [DIN_W-1:0]        peak_abs_o;
`endif

  hqc_rmdecod_findpeaks dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .din0_i       (din0_i),
    .din1_i       (din1_i),
    .din_valid_i  (din_valid_i),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o),
    .busy_o       (busy_o)
`ifdef HQC_FINDPEAKS_PEAKABS_EN
    ,
    .peak_abs_o   (peak_abs_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] dout_e;
    int         abs_e;
    int         cyc_e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: pair position and the coefficients of the block.
  int m_cnt = 0;
  int m_coef[128];
  int blk[128];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Peak = first coefficient (lowest index) attaining the maximum magnitude.
  function automatic void model_close(input int ecyc);
    exp_t e;
    int   best = 0;
    for (int i = 1; i < 128; i++)
      if (iabs(m_coef[i]) > iabs(m_coef[best])) best = i;
    e.dout_e = {m_coef[best] > 0, 7'(best)};
    e.abs_e  = iabs(m_coef[best]);
    e.cyc_e  = ecyc;
    sb.push_back(e);
  endfunction

  task automatic drive(input bit s, input bit v, input int a, input int b);
    @(posedge clk);
    #1;
    start_i     = s;
    din_valid_i = v;
    din0_i      = DIN_W'(a);
    din1_i      = DIN_W'(b);
    if (s) m_cnt = 0;
    if (v) begin
      m_coef[2*m_cnt]   = a;
      m_coef[2*m_cnt+1] = b;
      if (m_cnt == 63) model_close(cyc + 3);
      m_cnt = (m_cnt + 1) % 64;
    end
  endtask

  // Reset is applied together with start_i/din_valid_i to show its priority.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_i       = 1'b1;
    start_i     = 1'b1;
    din_valid_i = 1'b1;
    din0_i      = DIN_W'(100);
    din1_i      = '0;
    @(posedge clk);
    #1;
    rst_i       = 1'b0;
    start_i     = 1'b0;
    din_valid_i = 1'b0;
    m_cnt       = 0;
    check("reset_busy", busy_o, 0);
    check("reset_dout", dout_o, 0);
    check("reset_dout_valid", dout_valid_o, 0);
  endtask

  // mode: 0 = no start, 1 = start one cycle before pair 0, 2 = start with pair 0.
  task automatic send_block(input int mode, input int max_gap, input bit tail_idle);
    if (mode == 1) drive(1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 64; k++) begin
      repeat ($urandom_range(0, max_gap)) drive(1'b0, 1'b0, 0, 0);
      drive(mode == 2 && k == 0, 1'b1, blk[2*k], blk[2*k+1]);
      if (k == 1 && mode != 0) check("busy_in_block", busy_o, 1);
    end
    if (tail_idle) begin
      drive(1'b0, 1'b0, 0, 0);
      check("busy_after_block", busy_o, 0);
    end
  endtask

  task automatic fill_small(input int lim);
    for (int i = 0; i < 128; i++) blk[i] = int'($urandom_range(0, 2*lim)) - lim;
  endtask

  task automatic fill_zero();
    for (int i = 0; i < 128; i++) blk[i] = 0;
  endtask

  // Monitor: every output pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (dout_valid_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got dout=0x%0h with no block pending at cycle %0d",
                 dout_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("dout(peak_abs=%0d)", e.abs_e), dout_o, e.dout_e);
        check("latency_cycle", cyc, e.cyc_e);
`ifdef HQC_FINDPEAKS_PEAKABS_EN
        check("peak_abs", peak_abs_o, e.abs_e);
`endif
      end
    end
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; din_valid_i = 1'b0; din0_i = '0; din1_i = '0;
    do_reset();

    // Single positive peak at index 37 -> 0xA5.
    fill_zero(); blk[37] = 300;
    send_block(1, 0, 1'b1);

    // Most negative code at index 100, noise elsewhere -> 0x64, |x| = 512.
    fill_small(5); blk[100] = -512;
    send_block(1, 0, 1'b1);

    // Ties within and across pairs: earliest index of max |x| wins -> 0x05.
    fill_zero(); blk[0] = 7; blk[1] = 7; blk[5] = -200; blk[6] = 200;
    send_block(1, 0, 1'b1);

    // All zeros with idle gaps -> 0x00.
    fill_zero();
    send_block(1, 3, 1'b1);

    // Abandon a block at pair 20, then a full block with peak 9 = +50 -> 0x89.
    drive(1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 20; k++) drive(1'b0, 1'b1, 400, -400);
    fill_small(40); blk[9] = 50;
    send_block(1, 1, 1'b1);

    // Back-to-back blocks, second start the cycle after the last pair.
    fill_zero(); blk[37] = 300;
    send_block(1, 0, 1'b0);
    fill_small(10); blk[18] = -100;
    send_block(1, 0, 1'b1);

    // Start coinciding with pair 0, then a block with no start at all.
    fill_small(511);
    send_block(2, 1, 1'b1);
    fill_small(3);
    send_block(0, 0, 1'b1);

    // Reset in the middle of a block discards it.
    drive(1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 30; k++) drive(1'b0, 1'b1, -300, 300);
    do_reset();

    // Randomized blocks, some preceded by an abandoned partial block.
    for (int it = 0; it < 8; it++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b1, 1'b0, 0, 0);
        repeat ($urandom_range(1, 63)) drive(1'b0, 1'b1, int'($urandom_range(0, 1023)) - 512,
                                             int'($urandom_range(0, 1023)) - 512);
        mode = 1 + int'($urandom_range(0, 1));
      end
      case ($urandom_range(0, 2))
        0:       fill_small(3);
        1:       fill_small(511);
        default: begin fill_zero(); blk[$urandom_range(0, 127)] = -512; end
      endcase
      send_block(mode, 2, 1'b1);
    end

    repeat (8) drive(1'b0, 1'b0, 0, 0);
    check("pending_outputs", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
